// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with little-endian byte-lane writes and a two-cycle ERROR response.
// Define AHB_SRAM_WAIT_EN to insert WAIT_STATES wait cycles before every legal data phase.
module ahb_sram_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic                  Hclk,
    input  logic                  Hreset,
    input  logic                  Hsel,
    input  logic [ADDR_WIDTH-1:0] Haddr,
    input  logic [1:0]            Htrans,
    input  logic                  Hwrite,
    input  logic [2:0]            Hsize,
    input  logic [DATA_WIDTH-1:0] Hwdata,
    input  logic                  Hready,
    output logic [DATA_WIDTH-1:0] Hrdata,
    output logic [1:0]            Hresp,
    output logic                  Hreadyout
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int NB = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_ERR1,
        S_ERR2
`ifdef AHB_SRAM_WAIT_EN
        , S_WAIT
`endif
    } state_t;

    state_t                state_q;
    logic                  Hreadyout_q;
    logic [1:0]            Hresp_q;
    logic [AW-1:0]         idx_q;
    logic [1:0]            lo_q;
    logic [1:0]            size_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
`ifdef AHB_SRAM_WAIT_EN
    logic [3:0]            cnt_q;
`endif

    logic          addr_ph_ok;
    logic          accept;
    logic          unaligned;
    logic          legal;
    logic [NB-1:0] be;
    logic          unused_bits;

    // Only states that present Hreadyout=1 can take a new address phase.
    assign addr_ph_ok = (state_q == S_IDLE) || (state_q == S_ACCESS) || (state_q == S_ERR2);
    assign accept     = Hsel && Hready && Htrans[1] && addr_ph_ok;
    assign unaligned  = ((Hsize == 3'b001) && Haddr[0]) || ((Hsize == 3'b010) && (|Haddr[1:0]));
    assign legal      = (Hsize <= 3'b010) && !unaligned && !(|Haddr[ADDR_WIDTH-1:AW+2]);

`ifdef AHB_SRAM_WAIT_EN
    assign unused_bits = Htrans[0];
`else
    assign unused_bits = Htrans[0] ^ (WAIT_STATES != 0);
`endif

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_q     <= S_IDLE;
            Hreadyout_q <= 1'b1;
            Hresp_q     <= 2'b00;
`ifdef AHB_SRAM_WAIT_EN
            cnt_q       <= '0;
`endif
        end else if (accept) begin
            if (!legal) begin
                state_q     <= S_ERR1;
                Hreadyout_q <= 1'b0;
                Hresp_q     <= 2'b01;
`ifdef AHB_SRAM_WAIT_EN
            end else if (WAIT_STATES != 0) begin
                state_q     <= S_WAIT;
                cnt_q       <= 4'(WAIT_STATES);
                Hreadyout_q <= 1'b0;
                Hresp_q     <= 2'b00;
`endif
            end else begin
                state_q     <= S_ACCESS;
                Hreadyout_q <= 1'b1;
                Hresp_q     <= 2'b00;
            end
        end else begin
            case (state_q)
`ifdef AHB_SRAM_WAIT_EN
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q     <= S_ACCESS;
                        Hreadyout_q <= 1'b1;
                    end
                end
`endif
                S_ERR1: begin
                    state_q     <= S_ERR2;
                    Hreadyout_q <= 1'b1;
                    Hresp_q     <= 2'b01;
                end
                default: begin
                    state_q     <= S_IDLE;
                    Hreadyout_q <= 1'b1;
                    Hresp_q     <= 2'b00;
                end
            endcase
        end
    end

    always_ff @(posedge Hclk) begin
        if (accept) begin
            idx_q   <= Haddr[AW+1:2];
            lo_q    <= Haddr[1:0];
            size_q  <= Hsize[1:0];
            write_q <= Hwrite;
        end
    end

    always_comb begin
        be = '0;
        for (int b = 0; b < NB; b++) begin
            case (size_q)
                2'b00:   be[b] = (b[1:0] == lo_q);
                2'b01:   be[b] = (b[1] == lo_q[1]);
                default: be[b] = 1'b1;
            endcase
        end
    end

    // Memory is never reset; the commit happens at the edge closing the ACCESS cycle.
    always_ff @(posedge Hclk) begin
        if (!Hreset && (state_q == S_ACCESS) && write_q) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) mem_q[idx_q][8*b +: 8] <= Hwdata[8*b +: 8];
            end
        end
    end

    assign Hrdata    = ((state_q == S_ACCESS) && !write_q) ? mem_q[idx_q] : '0;
    assign Hresp     = Hresp_q;
    assign Hreadyout = Hreadyout_q;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave: directed vector table, hand sequences, and
// randomized pipelined traffic scored against a per-cycle response queue model.
module tb_ahb_sram_slave;
`ifdef AHB_SRAM_WAIT_EN
    localparam int WAITS = 2;
`else
    localparam int WAITS = 0;
`endif

    logic        Hclk, Hreset, Hsel, Hwrite;
    logic [31:0] Haddr, Hwdata, Hrdata;
    logic [1:0]  Htrans, Hresp;
    logic [2:0]  Hsize;
    logic        Hready, Hreadyout;

    assign Hready = Hreadyout;

    ahb_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(2)) dut (
        .Hclk(Hclk), .Hreset(Hreset), .Hsel(Hsel), .Haddr(Haddr), .Htrans(Htrans),
        .Hwrite(Hwrite), .Hsize(Hsize), .Hwdata(Hwdata), .Hready(Hready),
        .Hrdata(Hrdata), .Hresp(Hresp), .Hreadyout(Hreadyout)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    typedef struct packed {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    // One expected bus cycle of response.
    typedef struct packed {
        logic        rdy;
        logic [1:0]  resp;
        logic        acc;
        logic        last;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cyc_t;

    typedef struct {
        xfer_t       t;
        int          kind;   // 0 no transfer, 1 OKAY, 2 ERROR
        logic [31:0] rd;
    } vec_t;

    cyc_t        q[$];
    logic [31:0] mdl [1024];
    int          nvec = 0;
    int          nerr = 0;
    int          obs_low;
    logic [1:0]  obs_resp;
    logic [31:0] obs_rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic xfer_t mk(input logic sel, input logic [1:0] tr, input logic wr,
                                 input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
        xfer_t t;
        t.sel = sel; t.trans = tr; t.wr = wr; t.size = sz; t.addr = a; t.wdata = d;
        return t;
    endfunction

    function automatic bit legal(input xfer_t t);
        if (t.size > 3'd2) return 1'b0;
        if ((t.addr % (32'd1 << t.size)) != 0) return 1'b0;
        return t.addr < 32'd4096;
    endfunction

    task automatic push_xfer(input xfer_t t);
        cyc_t c;
        c = '0;
        c.wr = t.wr; c.size = t.size; c.addr = t.addr; c.wdata = t.wdata;
        if (legal(t)) begin
            for (int i = 0; i < WAITS; i++) q.push_back(c);
            c.rdy = 1'b1; c.acc = 1'b1; c.last = 1'b1;
            q.push_back(c);
        end else begin
            c.resp = 2'b01;
            q.push_back(c);
            c.rdy = 1'b1; c.last = 1'b1;
            q.push_back(c);
        end
    endtask

    // One bus cycle: check this cycle's response, then drive the next address phase.
    task automatic step(input bit go, input xfer_t t, output bit sent);
        cyc_t        e;
        logic [31:0] er;
        @(negedge Hclk);
        if (q.size() > 0) e = q.pop_front();
        else begin
            e = '0; e.rdy = 1'b1; e.wdata = $urandom;
        end
        er = (e.acc && !e.wr) ? mdl[e.addr[11:2]] : 32'h0;
        Hwdata = e.wdata;
        chk("hreadyout", 32'(Hreadyout), 32'(e.rdy));
        chk("hresp", 32'(Hresp), 32'(e.resp));
        chk("hrdata", Hrdata, er);
        if (!Hreadyout) obs_low++;
        if (e.last) begin
            obs_resp = Hresp; obs_rd = Hrdata;
        end
        if (e.acc && e.wr) begin
            for (int k = 0; k < (1 << e.size); k++) begin
                int ln;
                ln = int'(e.addr[1:0]) + k;
                mdl[e.addr[11:2]][8*ln +: 8] = e.wdata[8*ln +: 8];
            end
        end
        sent = go && e.rdy;
        if (sent) begin
            Hsel = t.sel; Htrans = t.trans; Hwrite = t.wr; Hsize = t.size; Haddr = t.addr;
            if (t.sel && t.trans[1]) push_xfer(t);
        end else begin
            Hsel = 1'($urandom); Haddr = $urandom; Hwrite = 1'($urandom); Hsize = 3'($urandom);
            Htrans = e.rdy ? {1'b0, 1'($urandom)} : 2'($urandom);
        end
    endtask

    task automatic send(input xfer_t t);
        bit s;
        s = 1'b0;
        for (int k = 0; k < 40 && !s; k++) step(1'b1, t, s);
        chk("send", 32'(s), 32'd1);
    endtask

    task automatic drain();
        bit    s;
        xfer_t z;
        z = '0;
        for (int k = 0; k < 40 && q.size() > 0; k++) step(1'b0, z, s);
        chk("drain", q.size(), 32'd0);
        q.delete();
    endtask

    task automatic do_reset();
        @(negedge Hclk);
        Hreset = 1'b1; Hsel = 1'b0; Htrans = 2'b00;
        q.delete();
        @(negedge Hclk);
        chk("rst_hreadyout", 32'(Hreadyout), 32'd1);
        chk("rst_hresp", 32'(Hresp), 32'd0);
        chk("rst_hrdata", Hrdata, 32'd0);
        Hreset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vt [18];
        xfer_t       t;
        logic [31:0] a;
        bit          s;

        Hreset = 1'b1; Hsel = 1'b0; Htrans = 2'b00; Hwrite = 1'b0; Hsize = 3'b010;
        Haddr = '0; Hwdata = '0;
        for (int i = 0; i < 1024; i++) mdl[i] = 32'h0;

        vt[0]  = '{t: mk(1, 2'b10, 1, 3'd2, 32'h10,  32'hCAFEF00D), kind: 1, rd: 32'h0};
        vt[1]  = '{t: mk(1, 2'b10, 0, 3'd2, 32'h10,  32'h0),        kind: 1, rd: 32'hCAFEF00D};
        vt[2]  = '{t: mk(1, 2'b10, 1, 3'd2, 32'h10,  32'h0),        kind: 1, rd: 32'h0};
        vt[3]  = '{t: mk(1, 2'b10, 1, 3'd0, 32'h11,  32'hFFFFABFF), kind: 1, rd: 32'h0};
        vt[4]  = '{t: mk(1, 2'b10, 0, 3'd2, 32'h10,  32'h0),        kind: 1, rd: 32'h0000AB00};
        vt[5]  = '{t: mk(1, 2'b10, 1, 3'd1, 32'h13,  32'hFFFFFFFF), kind: 2, rd: 32'h0};
        vt[6]  = '{t: mk(1, 2'b10, 0, 3'd2, 32'h10,  32'h0),        kind: 1, rd: 32'h0000AB00};
        vt[7]  = '{t: mk(1, 2'b10, 0, 3'd2, 32'h1000, 32'h0),       kind: 2, rd: 32'h0};
        vt[8]  = '{t: mk(1, 2'b00, 0, 3'd2, 32'h10,  32'h0),        kind: 0, rd: 32'h0};
        vt[9]  = '{t: mk(1, 2'b10, 0, 3'd3, 32'h0,   32'h0),        kind: 2, rd: 32'h0};
        vt[10] = '{t: mk(1, 2'b10, 1, 3'd1, 32'h12,  32'hBEEF1111), kind: 1, rd: 32'h0};
        vt[11] = '{t: mk(0, 2'b10, 1, 3'd2, 32'h10,  32'hFFFFFFFF), kind: 0, rd: 32'h0};
        vt[12] = '{t: mk(1, 2'b11, 0, 3'd2, 32'h10,  32'h0),        kind: 1, rd: 32'hBEEFAB00};
        vt[13] = '{t: mk(1, 2'b01, 1, 3'd2, 32'h10,  32'h0),        kind: 0, rd: 32'h0};
        vt[14] = '{t: mk(1, 2'b10, 0, 3'd0, 32'h11,  32'h0),        kind: 1, rd: 32'hBEEFAB00};
        vt[15] = '{t: mk(1, 2'b10, 1, 3'd2, 32'h2,   32'h12345678), kind: 2, rd: 32'h0};
        vt[16] = '{t: mk(1, 2'b10, 1, 3'd2, 32'hFFC, 32'h5A5AA5A5), kind: 1, rd: 32'h0};
        vt[17] = '{t: mk(1, 2'b10, 0, 3'd2, 32'hFFC, 32'h0),        kind: 1, rd: 32'h5A5AA5A5};

        do_reset();

        // Known contents for the words the random phase touches.
        for (int i = 0; i < 16; i++) send(mk(1, 2'b10, 1, 3'd2, 32'(i * 4), 32'h0));
        drain();

        for (int i = 0; i < 18; i++) begin
            obs_low = 0;
            send(vt[i].t);
            drain();
            if (vt[i].kind != 0) begin
                chk($sformatf("tbl%0d_lowcycles", i), 32'(obs_low), (vt[i].kind == 2) ? 32'd1 : 32'(WAITS));
                chk($sformatf("tbl%0d_resp", i), 32'(obs_resp), (vt[i].kind == 2) ? 32'd1 : 32'd0);
                if (vt[i].kind == 1 && !vt[i].t.wr)
                    chk($sformatf("tbl%0d_rdata", i), obs_rd, vt[i].rd);
            end
        end

        // Pipelined writes, then read-after-write of the same word with no gap.
        send(mk(1, 2'b10, 1, 3'd2, 32'h0, 32'h11112222));
        send(mk(1, 2'b10, 1, 3'd2, 32'h4, 32'h33334444));
        send(mk(1, 2'b10, 0, 3'd2, 32'h4, 32'h0));
        obs_rd = 32'h0;
        send(mk(1, 2'b10, 0, 3'd2, 32'h0, 32'h0));
        drain();
        chk("b2b_rdata0", obs_rd, 32'h11112222);

        // Reset in the middle of a write must leave the target word untouched.
        send(mk(1, 2'b10, 1, 3'd2, 32'h8, 32'h0BADBEEF));
        drain();
        if (WAITS > 0) send(mk(1, 2'b10, 1, 3'd2, 32'h8, 32'hDEADDEAD));
        else           send(mk(1, 2'b10, 1, 3'd2, 32'hA, 32'hDEADDEAD));
        do_reset();
        obs_rd = 32'h0;
        send(mk(1, 2'b10, 0, 3'd2, 32'h8, 32'h0));
        drain();
        chk("rst_abort_rdata", obs_rd, 32'h0BADBEEF);

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 7))
                0:       a = 32'h1000 + $urandom_range(0, 255);
                1:       a = $urandom;
                default: a = $urandom_range(0, 63);
            endcase
            t = mk(($urandom_range(0, 7) != 0), 2'($urandom), 1'($urandom),
                   3'($urandom_range(0, 3)), a, $urandom);
            step(($urandom_range(0, 3) != 0), t, s);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
